// File: rtl/next_pc_gen_if.sv
// Handshake bundle between decode/ALU (master) and the next-PC generator (slave).
interface next_pc_gen_if #(
  parameter int XLEN = 32,
  parameter int OFFW = 16,
  parameter int JMPW = 26
);
  logic            stall;
  logic            zero_flag;
  logic            carry_flag;
  logic            msb;
  logic            overflow;
  logic [3:0]      brtype;
  logic [OFFW-1:0] branch_offset;
  logic [2:0]      pc_sel;
  logic [JMPW-1:0] jmp_label;
  logic [XLEN-1:0] jmp_ra;
  logic [XLEN-1:0] pc;
  logic            redirect;
  logic            ras_empty;
  logic            ras_full;

  modport master (
    output stall, zero_flag, carry_flag, msb, overflow, brtype,
           branch_offset, pc_sel, jmp_label, jmp_ra,
    input  pc, redirect, ras_empty, ras_full
  );

  modport slave (
    input  stall, zero_flag, carry_flag, msb, overflow, brtype,
           branch_offset, pc_sel, jmp_label, jmp_ra,
    output pc, redirect, ras_empty, ras_full
  );
endinterface

// File: rtl/next_pc_gen.sv
// Next-PC generator: owns the PC register, resolves branch conditions from
// ALU flags, forms jump/call/return targets and keeps a circular
// return-address stack so returns resolve without a register read.
module next_pc_gen #(
  parameter int              XLEN      = 32,
  parameter int              OFFW      = 16,
  parameter int              JMPW      = 26,
  parameter int              RAS_DEPTH = 4,
  parameter logic [XLEN-1:0] RESET_PC  = '0
) (
  input logic          clk,
  input logic          reset,
  next_pc_gen_if.slave bus
);

  localparam int PTRW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam int CNTW = $clog2(RAS_DEPTH + 1);
  localparam logic [CNTW-1:0] CNT_FULL = CNTW'(RAS_DEPTH);

  // Condition select: 0 always, odd/even pairs test a flag and its inverse.
  function automatic logic branch_taken(input logic [3:0] bt, input logic z,
                                        input logic c, input logic m,
                                        input logic o);
    logic t;
    case (bt)
      4'd0:    t = 1'b1;
      4'd1:    t = z;
      4'd2:    t = ~z;
      4'd3:    t = c;
      4'd4:    t = ~c;
      4'd5:    t = m;
      4'd6:    t = ~m;
      4'd7:    t = o;
      4'd8:    t = ~o;
      default: t = 1'b0;
    endcase
    return t;
  endfunction

  logic [XLEN-1:0]        pc_p1;
  logic                   redirect_p1;
  logic [PTRW-1:0]        top_p1;
  logic [CNTW-1:0]        cnt_p1;
  logic [XLEN-1:0]        ras_mem [RAS_DEPTH];

  logic                   taken;
  logic signed [XLEN-1:0] off_sext;
  logic [XLEN-1:0]        seq_pc;
  logic [XLEN-1:0]        br_tgt;
  logic [XLEN-1:0]        jtarget;
  logic [XLEN-1:0]        next_pc;
  logic [PTRW-1:0]        top_inc;
  logic [PTRW-1:0]        top_dec;
  logic                   ras_empty_w;
  logic                   push;
  logic                   pop;

  assign ras_empty_w = (cnt_p1 == '0);
  assign top_inc     = top_p1 + PTRW'(1);
  assign top_dec     = top_p1 - PTRW'(1);

  // Target formation: sequential, PC-relative branch and region-local jump.
  always_comb begin
    taken    = branch_taken(bus.brtype, bus.zero_flag, bus.carry_flag,
                            bus.msb, bus.overflow);
    off_sext = {{(XLEN-OFFW){bus.branch_offset[OFFW-1]}}, bus.branch_offset};
    seq_pc   = pc_p1 + XLEN'(1);
    br_tgt   = taken ? (seq_pc + off_sext) : seq_pc;
    // Upper PC bits keep the current region; the label fills the rest.
    jtarget             = pc_p1;
    jtarget[JMPW+1:0]   = {bus.jmp_label, 2'b00};
  end

  // Target select plus RAS push/pop decisions; an empty RAS falls back to jmp_ra.
  always_comb begin
    next_pc = seq_pc;
    push    = 1'b0;
    pop     = 1'b0;
    case (bus.pc_sel)
      3'd0: next_pc = br_tgt;
      3'd1: next_pc = jtarget;
      3'd2: next_pc = bus.jmp_ra;
      3'd3: begin
        next_pc = jtarget;
        push    = 1'b1;
      end
      3'd4: begin
        if (!ras_empty_w) begin
          next_pc = ras_mem[top_p1];
          pop     = 1'b1;
        end else begin
          next_pc = bus.jmp_ra;
        end
      end
      default: next_pc = seq_pc;
    endcase
  end

  // ---- stage boundary: architectural PC, redirect flag and RAS pointers ----
  // Control state; a stall freezes everything except clearing redirect.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_p1       <= RESET_PC;
      redirect_p1 <= 1'b0;
      top_p1      <= '0;
      cnt_p1      <= '0;
    end else if (!bus.stall) begin
      pc_p1       <= next_pc;
      redirect_p1 <= (next_pc != seq_pc);
      if (push) begin
        top_p1 <= top_inc;
        // Full push overwrites the oldest slot, so the count saturates.
        if (cnt_p1 != CNT_FULL) cnt_p1 <= cnt_p1 + CNTW'(1);
      end else if (pop) begin
        top_p1 <= top_dec;
        cnt_p1 <= cnt_p1 - CNTW'(1);
      end
    end else begin
      redirect_p1 <= 1'b0;
    end
  end

  // RAS storage holds data only, so it carries no reset.
  always_ff @(posedge clk) begin
    if (!bus.stall && push) ras_mem[top_inc] <= seq_pc;
  end

  assign bus.pc        = pc_p1;
  assign bus.redirect  = redirect_p1;
  assign bus.ras_empty = ras_empty_w;
  assign bus.ras_full  = (cnt_p1 == CNT_FULL);

endmodule

// File: tb/tb_next_pc_gen.sv
// Self-checking bench for next_pc_gen: directed scenarios plus randomized
// traffic compared against a queue-based reference model.
module tb_next_pc_gen;
  localparam int XLEN = 32;
  localparam int OFFW = 16;
  localparam int JMPW = 26;
  localparam int RAS_DEPTH = 4;
  localparam logic [XLEN-1:0] RESET_PC = '0;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  next_pc_gen_if #(.XLEN(XLEN), .OFFW(OFFW), .JMPW(JMPW)) bus ();

  next_pc_gen #(.XLEN(XLEN), .OFFW(OFFW), .JMPW(JMPW), .RAS_DEPTH(RAS_DEPTH),
                .RESET_PC(RESET_PC)) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state: PC, redirect and the RAS as a bounded queue
  // (back = most recent push, front = oldest).
  logic [XLEN-1:0] m_pc;
  logic            m_redirect;
  logic [XLEN-1:0] m_ras[$];

  function automatic bit cond_ok(input logic [3:0] bt, input logic [3:0] fl);
    // fl = {zero, carry, msb, overflow}
    case (bt)
      4'd0: return 1'b1;
      4'd1: return fl[3];
      4'd2: return !fl[3];
      4'd3: return fl[2];
      4'd4: return !fl[2];
      4'd5: return fl[1];
      4'd6: return !fl[1];
      4'd7: return fl[0];
      4'd8: return !fl[0];
      default: return 1'b0;
    endcase
  endfunction

  task automatic model_reset();
    m_pc = RESET_PC;
    m_redirect = 1'b0;
    m_ras.delete();
  endtask

  // Apply one cycle of inputs, advance the model, and settle 1 time unit past the edge.
  task automatic drive(input bit st, input logic [3:0] fl, input logic [3:0] bt,
                       input logic [OFFW-1:0] off, input logic [2:0] sel,
                       input logic [JMPW-1:0] lbl, input logic [XLEN-1:0] ra);
    logic [XLEN-1:0] seq, nxt, sx, jt;
    bus.stall = st;
    {bus.zero_flag, bus.carry_flag, bus.msb, bus.overflow} = fl;
    bus.brtype = bt;
    bus.branch_offset = off;
    bus.pc_sel = sel;
    bus.jmp_label = lbl;
    bus.jmp_ra = ra;
    if (!st) begin
      seq = m_pc + 1;
      sx  = XLEN'($signed(off));
      jt  = ((m_pc >> (JMPW + 2)) << (JMPW + 2)) | (XLEN'(lbl) << 2);
      case (sel)
        3'd0: nxt = cond_ok(bt, fl) ? seq + sx : seq;
        3'd1: nxt = jt;
        3'd2: nxt = ra;
        3'd3: nxt = jt;
        3'd4: nxt = (m_ras.size() > 0) ? m_ras.pop_back() : ra;
        default: nxt = seq;
      endcase
      if (sel == 3'd3) begin
        m_ras.push_back(seq);
        if (m_ras.size() > RAS_DEPTH) void'(m_ras.pop_front());
      end
      m_redirect = (nxt != seq);
      m_pc = nxt;
    end else begin
      m_redirect = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic go_to(input logic [XLEN-1:0] a);
    drive(1'b0, 4'h0, 4'd9, '0, 3'd2, '0, a);
  endtask

  task automatic call(input logic [JMPW-1:0] lbl);
    drive(1'b0, 4'h0, 4'd9, '0, 3'd3, lbl, '0);
  endtask

  task automatic ret(input logic [XLEN-1:0] ra);
    drive(1'b0, 4'h0, 4'd9, '0, 3'd4, '0, ra);
  endtask

  task automatic test_reset();
    bus.stall = 1'b0; bus.zero_flag = 1'b0; bus.carry_flag = 1'b0;
    bus.msb = 1'b0; bus.overflow = 1'b0; bus.brtype = 4'd9;
    bus.branch_offset = '0; bus.pc_sel = 3'd0; bus.jmp_label = '0; bus.jmp_ra = '0;
    reset = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #2 reset = 1'b0;
    model_reset();
    #1;
    n_cmp++; if (bus.pc !== RESET_PC) begin n_bad++; $display("FAIL reset_pc got %h want %h", bus.pc, RESET_PC); end
    n_cmp++; if (bus.redirect !== 1'b0) begin n_bad++; $display("FAIL reset_redirect got %b want 0", bus.redirect); end
    n_cmp++; if (bus.ras_empty !== 1'b1) begin n_bad++; $display("FAIL reset_empty got %b want 1", bus.ras_empty); end
    n_cmp++; if (bus.ras_full !== 1'b0) begin n_bad++; $display("FAIL reset_full got %b want 0", bus.ras_full); end
  endtask

  task automatic test_sequential();
    for (int i = 1; i <= 4; i++) begin
      drive(1'b0, 4'h0, 4'd9, '0, 3'd0, '0, '0);
      n_cmp++; if (bus.pc !== XLEN'(i)) begin n_bad++; $display("FAIL seq_pc[%0d] got %h want %h", i, bus.pc, XLEN'(i)); end
      n_cmp++; if (bus.redirect !== 1'b0) begin n_bad++; $display("FAIL seq_redirect[%0d] got %b want 0", i, bus.redirect); end
      n_cmp++; if (bus.ras_empty !== 1'b1) begin n_bad++; $display("FAIL seq_empty[%0d] got %b want 1", i, bus.ras_empty); end
    end
  endtask

  task automatic test_branch();
    go_to(32'h10);
    drive(1'b0, 4'b1000, 4'd1, 16'hFFFC, 3'd0, '0, '0);
    n_cmp++; if (bus.pc !== 32'h0D) begin n_bad++; $display("FAIL br_taken_pc got %h want 0000000d", bus.pc); end
    n_cmp++; if (bus.redirect !== 1'b1) begin n_bad++; $display("FAIL br_taken_redirect got %b want 1", bus.redirect); end
    go_to(32'h10);
    drive(1'b0, 4'b0000, 4'd1, 16'hFFFC, 3'd0, '0, '0);
    n_cmp++; if (bus.pc !== 32'h11) begin n_bad++; $display("FAIL br_nt_pc got %h want 00000011", bus.pc); end
    n_cmp++; if (bus.redirect !== 1'b0) begin n_bad++; $display("FAIL br_nt_redirect got %b want 0", bus.redirect); end
    go_to(32'h10);
    drive(1'b0, 4'b1111, 4'd12, 16'hFFFC, 3'd0, '0, '0);
    n_cmp++; if (bus.pc !== 32'h11) begin n_bad++; $display("FAIL br_bt12_pc got %h want 00000011", bus.pc); end
    drive(1'b0, 4'b0000, 4'd0, 16'h0000, 3'd0, '0, '0);
    n_cmp++; if (bus.pc !== 32'h12) begin n_bad++; $display("FAIL br_off0_pc got %h want 00000012", bus.pc); end
    n_cmp++; if (bus.redirect !== 1'b0) begin n_bad++; $display("FAIL br_off0_redirect got %b want 0", bus.redirect); end
    drive(1'b0, 4'b0100, 4'd3, 16'h0010, 3'd0, '0, '0);
    n_cmp++; if (bus.pc !== 32'h23) begin n_bad++; $display("FAIL br_carry_pc got %h want 00000023", bus.pc); end
  endtask

  task automatic test_jump();
    go_to(32'hA000_0010);
    drive(1'b0, 4'h0, 4'd9, '0, 3'd1, 26'h40, '0);
    n_cmp++; if (bus.pc !== 32'hA000_0100) begin n_bad++; $display("FAIL jmp_pc got %h want a0000100", bus.pc); end
    n_cmp++; if (bus.redirect !== 1'b1) begin n_bad++; $display("FAIL jmp_redirect got %b want 1", bus.redirect); end
    drive(1'b0, 4'h0, 4'd9, '0, 3'd2, '0, 32'h1234);
    n_cmp++; if (bus.pc !== 32'h1234) begin n_bad++; $display("FAIL jr_pc got %h want 00001234", bus.pc); end
  endtask

  task automatic test_call_return();
    go_to(32'h20);
    call(26'h10);
    n_cmp++; if (bus.pc !== 32'h40) begin n_bad++; $display("FAIL call_pc got %h want 00000040", bus.pc); end
    n_cmp++; if (bus.ras_empty !== 1'b0) begin n_bad++; $display("FAIL call_empty got %b want 0", bus.ras_empty); end
    ret(32'h0);
    n_cmp++; if (bus.pc !== 32'h21) begin n_bad++; $display("FAIL ret_pc got %h want 00000021", bus.pc); end
    n_cmp++; if (bus.ras_empty !== 1'b1) begin n_bad++; $display("FAIL ret_empty got %b want 1", bus.ras_empty); end
    ret(32'h99);
    n_cmp++; if (bus.pc !== 32'h99) begin n_bad++; $display("FAIL ret_fallback_pc got %h want 00000099", bus.pc); end
  endtask

  task automatic test_ras_overflow();
    for (int i = 0; i < 5; i++) begin
      go_to(XLEN'(32'h1000 * (i + 1)));
      call(JMPW'(i + 1));
    end
    n_cmp++; if (bus.ras_full !== 1'b1) begin n_bad++; $display("FAIL ovf_full got %b want 1", bus.ras_full); end
    for (int i = 4; i >= 1; i--) begin
      ret(32'h55);
      n_cmp++; if (bus.pc !== XLEN'(32'h1000 * (i + 1) + 1)) begin n_bad++; $display("FAIL ovf_ret[%0d] got %h want %h", i, bus.pc, XLEN'(32'h1000 * (i + 1) + 1)); end
    end
    n_cmp++; if (bus.ras_empty !== 1'b1) begin n_bad++; $display("FAIL ovf_empty got %b want 1", bus.ras_empty); end
    ret(32'h77);
    n_cmp++; if (bus.pc !== 32'h77) begin n_bad++; $display("FAIL ovf_lost got %h want 00000077", bus.pc); end
  endtask

  task automatic test_stall();
    go_to(32'h300);
    call(26'h20);
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 4'h0, 4'd9, '0, 3'd3, 26'h3F, '0);
      n_cmp++; if (bus.pc !== 32'h80) begin n_bad++; $display("FAIL stall_pc[%0d] got %h want 00000080", i, bus.pc); end
      n_cmp++; if (bus.redirect !== 1'b0) begin n_bad++; $display("FAIL stall_redirect[%0d] got %b want 0", i, bus.redirect); end
      n_cmp++; if (bus.ras_empty !== 1'b0) begin n_bad++; $display("FAIL stall_empty[%0d] got %b want 0", i, bus.ras_empty); end
    end
    ret(32'h5);
    n_cmp++; if (bus.pc !== 32'h301) begin n_bad++; $display("FAIL stall_ret got %h want 00000301", bus.pc); end
    ret(32'h66);
    n_cmp++; if (bus.pc !== 32'h66) begin n_bad++; $display("FAIL stall_ret2 got %h want 00000066", bus.pc); end
  endtask

  task automatic test_reset_mid_call();
    go_to(32'h400);
    call(26'h1);
    call(26'h2);
    #2;
    bus.stall = 1'b1;
    bus.pc_sel = 3'd3;
    reset = 1'b1;
    #1;
    n_cmp++; if (bus.pc !== RESET_PC) begin n_bad++; $display("FAIL arst_pc got %h want %h", bus.pc, RESET_PC); end
    n_cmp++; if (bus.ras_empty !== 1'b1) begin n_bad++; $display("FAIL arst_empty got %b want 1", bus.ras_empty); end
    n_cmp++; if (bus.redirect !== 1'b0) begin n_bad++; $display("FAIL arst_redirect got %b want 0", bus.redirect); end
    @(posedge clk);
    #3 reset = 1'b0;
    model_reset();
    drive(1'b0, 4'h0, 4'd9, '0, 3'd0, '0, '0);
    n_cmp++; if (bus.pc !== RESET_PC + 1) begin n_bad++; $display("FAIL arst_resume got %h want %h", bus.pc, RESET_PC + 1); end
    ret(32'hAB);
    n_cmp++; if (bus.pc !== 32'hAB) begin n_bad++; $display("FAIL arst_ras_cleared got %h want 000000ab", bus.pc); end
  endtask

  task automatic test_random();
    logic [OFFW-1:0] off;
    for (int i = 0; i < 400; i++) begin
      off = OFFW'($urandom);
      if (off == '1) off = '0;
      drive(($urandom_range(0, 9) == 0), 4'($urandom), 4'($urandom), off,
            3'($urandom_range(0, 7)), JMPW'($urandom), XLEN'($urandom));
      n_cmp++; if (bus.pc !== m_pc) begin n_bad++; $display("FAIL rnd_pc[%0d] got %h want %h", i, bus.pc, m_pc); end
      n_cmp++; if (bus.redirect !== m_redirect) begin n_bad++; $display("FAIL rnd_redirect[%0d] got %b want %b", i, bus.redirect, m_redirect); end
      n_cmp++; if (bus.ras_empty !== (m_ras.size() == 0)) begin n_bad++; $display("FAIL rnd_empty[%0d] got %b want %b", i, bus.ras_empty, m_ras.size() == 0); end
      n_cmp++; if (bus.ras_full !== (m_ras.size() == RAS_DEPTH)) begin n_bad++; $display("FAIL rnd_full[%0d] got %b want %b", i, bus.ras_full, m_ras.size() == RAS_DEPTH); end
    end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_branch();
    test_jump();
    test_call_return();
    test_ras_overflow();
    test_stall();
    test_reset_mid_call();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
